sc_eval_unit: RTL and testbench
===============================

Name: sc_eval_unit

Overview:
- Parametrised stochastic-computing evaluation engine.
- Converts N_CH binary operands into bitstreams using one shared LFSR and per-channel comparators.
- Combines the bitstreams through a run-time selectable SC function and counts the ones over a fixed stream length.
- Returns the binary estimate with a start/done handshake; sits between the binary datapath and SC kernels.

Parameters:
- WIDTH, 8, operand and LFSR width.
- N_CH, 2, operand channels (≥2).
- STREAM_LEN, 255, evaluation cycles per run (1..2^WIDTH-1).
- SEED, 8'h01, LFSR load value; must be nonzero.
- TAPS, 8'h2D, LFSR feedback mask; must be a maximal-length polynomial.
- ROT, 3, per-channel rotation step (decorrelation).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  run request.
- mode_i  in  2  0=AND multiply, 1=MUX scaled add, 2=affine 0.5+0.25·p0, 3=reserved (treated as 0).
- x_i  in  N_CH*WIDTH  operands; channel k at [k*WIDTH +: WIDTH].
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse, result valid.
- result_o  out  RW=clog2(STREAM_LEN+1)  ones count of last run.
- stream_o  out  1  current SC output bit.
- stream_vld_o  out  1  stream_o valid (RUN only).

Behaviour:
- Reset (rst=1 at clk edge) values: state=IDLE, lfsr=SEED, busy_o=0, done_o=0, result_o=0, stream_o=0, stream_vld_o=0, all counters 0. Reset mid-run aborts with no done pulse.
- LFSR: each advance sets next = {^(lfsr & TAPS), lfsr[WIDTH-1:1]} (shift right, parity into MSB). The LFSR advances only in RUN.
- Channel k random value r_k = lfsr rotated left by (k*ROT mod WIDTH).
- Channel k SNG bit b_k = (r_k < xq_k), unsigned, where xq is the captured operand. P(b_k) = xq_k/2^WIDTH.
- Mode functions:
  - mode 0: AND of all b_k.
  - mode 1: lfsr[WIDTH-1] ? b_1 : b_0.
  - mode 2: ~(lfsr[WIDTH-1] & ~(b_0 & lfsr[WIDTH-2])).
- States:
  - IDLE: start_i=1 → capture x_i into xq and mode_i into mq, lfsr<=SEED, ones<=0, cnt<=0, busy_o<=1, go to RUN. start_i=0 → stay.
  - RUN: every cycle stream_o/stream_vld_o<=f(current lfsr, xq, mq)/1, ones<=ones+f, cnt<=cnt+1, lfsr advances. When cnt==STREAM_LEN-1, go to DONE with result_o<=final ones (including this cycle's bit).
  - DONE: done_o=1 and busy_o=0 for exactly one cycle, then IDLE. A start_i seen in DONE is accepted exactly as in IDLE.
  - start_i is ignored in RUN; captured operands are immune to x_i changes mid-run.
- Latency: done_o asserts STREAM_LEN+1 cycles after the start_i cycle.
- result_o holds until the next completed run; it is not cleared by start.
- ones saturates at STREAM_LEN by construction, so there is no overflow.

Decomposition:
- Shared package sc_pkg holds:
  - mode encodings (SC_MODE_AND, SC_MODE_MUX, SC_MODE_AFF);
  - FSM state typedef;
  - default SEED/TAPS constants.
- One sub-module, sc_lfsr (WIDTH, SEED, TAPS; inputs load and en), reused by later SC blocks.
- Comparators and the function mux stay inline.

Test Plan:
- Period check, default TAPS/SEED: the LFSR returns to SEED after exactly 255 advances and visits every nonzero value once.
- mode 0, x0=128, x1=255, STREAM_LEN=255 → result_o equals a bit-exact reference model. Separately, for a channel with x=0, count is 0; for x=255, count is 254.
- Handshake: start_i pulse → busy_o high the next cycle, done_o one-cycle pulse 256 cycles after start. start_i held high through RUN causes no restart; start_i in the DONE cycle immediately begins a second run.
- Operand capture: change x_i and mode_i every cycle during RUN → result_o identical to a run with static values.
- Reset mid-run (rst at cycle 100): no done_o, busy_o=0, result_o=0, stream_vld_o=0. The next run gives the same result as a clean run.
- Modes 1 and 2 with random operands, 200 runs: result_o matches the cycle-accurate model exactly; the mean error versus the ideal probability·255 stays within ±8.

Source files
------------

// File: rtl/sc_eval_unit_pkg.sv
// sc_pkg: shared definitions for the stochastic-computing blocks.
//   - SC function select encodings
//   - evaluation FSM state type
//   - default LFSR seed and feedback mask (x^8 maximal-length polynomial)
package sc_pkg;

    typedef enum logic [1:0] {
        SC_MODE_AND = 2'd0,   // product of all channel probabilities
        SC_MODE_MUX = 2'd1,   // 0.5*(p0 + p1)
        SC_MODE_AFF = 2'd2,   // 0.5 + 0.25*p0
        SC_MODE_RSV = 2'd3    // reserved, evaluates as AND
    } sc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sc_state_e;

    localparam logic [7:0] SC_SEED_DEF = 8'h01;
    localparam logic [7:0] SC_TAPS_DEF = 8'h2D;

endpackage

// File: rtl/sc_eval_unit_if.sv
// sc_eval_if: request/response bundle of the SC evaluation unit.
//   start_i, mode_i, x_i           : run request, function select, packed operands
//   busy_o, done_o, result_o       : run status and ones count of the last run
//   stream_o, stream_vld_o         : live SC output bit and its valid
// master = requester side, slave = sc_eval_unit.
interface sc_eval_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 2,
    parameter int RW    = 8
);
    logic                    start_i;
    logic [1:0]              mode_i;
    logic [N_CH*WIDTH-1:0]   x_i;
    logic                    busy_o;
    logic                    done_o;
    logic [RW-1:0]           result_o;
    logic                    stream_o;
    logic                    stream_vld_o;

    modport master (
        output start_i, mode_i, x_i,
        input  busy_o, done_o, result_o, stream_o, stream_vld_o
    );

    modport slave (
        input  start_i, mode_i, x_i,
        output busy_o, done_o, result_o, stream_o, stream_vld_o
    );
endinterface

// File: rtl/sc_eval_unit_lfsr.sv
// sc_lfsr: right-shifting Fibonacci LFSR, parity of (value & TAPS) enters the MSB.
//   clk, rst : clock, synchronous active-high reset (loads SEED)
//   load     : reload SEED (wins over en)
//   en       : advance one step
//   value    : current LFSR state
module sc_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter logic [WIDTH-1:0] TAPS  = 8'h2D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clk) begin
        if (rst || load)
            value <= SEED;
        else if (en)
            value <= {^(value & TAPS), value[WIDTH-1:1]};
    end
endmodule

// File: rtl/sc_eval_unit.sv
// sc_eval_unit: stochastic-computing evaluation engine.
// Each run captures N_CH operands and a function select, turns every operand
// into a bitstream (shared LFSR, per-channel rotation + comparator), combines
// the streams and counts ones over STREAM_LEN cycles.
//   clk, rst : clock, synchronous active-high reset (aborts a run, no done)
//   bus      : sc_eval_if.slave (start/mode/x in; busy/done/result/stream out)
module sc_eval_unit
    import sc_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               N_CH       = 2,
    parameter int               STREAM_LEN = 255,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(SC_SEED_DEF),
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(SC_TAPS_DEF),
    parameter int               ROT        = 3
) (
    input  logic    clk,
    input  logic    rst,
    sc_eval_if.slave bus
);
    localparam int            RW   = $clog2(STREAM_LEN + 1);
    localparam logic [RW-1:0] LAST = RW'(STREAM_LEN - 1);

    sc_state_e                   state, state_n;
    sc_mode_e                    mq;
    logic [N_CH-1:0][WIDTH-1:0]  xq;
    logic [WIDTH-1:0]            lfsr;
    logic [RW-1:0]               ones, cnt, result_q;
    logic                        stream_q, vld_q;
    logic [N_CH-1:0]             b;
    logic                        f, accept, last, busy, done;

    assign last = (state == ST_RUN) && (cnt == LAST);

    // ---- FSM ----
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // DONE accepts a new start exactly like IDLE, so back-to-back runs lose no cycle.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: if (bus.start_i) begin
                state_n = ST_RUN;
                accept  = 1'b1;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_n = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (bus.start_i) begin
                    state_n = ST_RUN;
                    accept  = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ---- shared random source ----
    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED), .TAPS(TAPS)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .en    (state == ST_RUN),
        .value (lfsr)
    );

    // ---- per-channel SNGs: rotating the shared LFSR decorrelates channels ----
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam int SH = (k * ROT) % WIDTH;
        logic [WIDTH-1:0] r;
        assign r    = (lfsr << SH) | (lfsr >> ((WIDTH - SH) % WIDTH));
        assign b[k] = (r < xq[k]);
    end

    // ---- SC function; the LFSR top bits serve as the 0.5 select/constant streams ----
    always_comb begin
        f = &b;
        case (mq)
            SC_MODE_MUX: f = lfsr[WIDTH-1] ? b[1] : b[0];
            SC_MODE_AFF: f = ~(lfsr[WIDTH-1] & ~(b[0] & lfsr[WIDTH-2]));
            default:     f = &b;
        endcase
    end

    // ---- datapath ----
    always_ff @(posedge clk) begin
        if (rst) begin
            xq       <= '0;
            mq       <= SC_MODE_AND;
            ones     <= '0;
            cnt      <= '0;
            result_q <= '0;
            stream_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            stream_q <= 1'b0;
            vld_q    <= 1'b0;
            if (accept) begin
                xq   <= bus.x_i;
                mq   <= sc_mode_e'(bus.mode_i);
                ones <= '0;
                cnt  <= '0;
            end else if (state == ST_RUN) begin
                stream_q <= f;
                vld_q    <= 1'b1;
                ones     <= ones + RW'(f);
                cnt      <= cnt + RW'(1);
                if (last) result_q <= ones + RW'(f);
            end
        end
    end

    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.result_o     = result_q;
    assign bus.stream_o     = stream_q;
    assign bus.stream_vld_o = vld_q;

endmodule

// File: tb/tb_sc_eval_unit.sv
// Directed bench for sc_eval_unit (WIDTH=8, N_CH=2, STREAM_LEN=255, defaults).
module tb_sc_eval_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lf_load = 1'b0, lf_en = 1'b0;
    logic [7:0] lf_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sc_eval_if #(.WIDTH(8), .N_CH(2), .RW(8)) bus ();

    sc_eval_unit #(
        .WIDTH(8), .N_CH(2), .STREAM_LEN(255), .SEED(8'h01), .TAPS(8'h2D), .ROT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sc_lfsr #(.WIDTH(8), .SEED(8'h01), .TAPS(8'h2D)) u_lfsr_chk (
        .clk (clk), .rst (rst), .load (lf_load), .en (lf_en), .value (lf_val)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: 8-bit LFSR from 0x01, ch1 rotated left by 3, 255 cycles.
    function automatic int model(input int mode, input int x0, input int x1);
        int l, ones, r1, p;
        bit b0, b1, msb, l6, f;
        l = 1;
        ones = 0;
        for (int i = 0; i < 255; i++) begin
            r1  = ((l * 8) + (l / 32)) % 256;
            b0  = (l < x0);
            b1  = (r1 < x1);
            msb = (l / 128) % 2;
            l6  = (l / 64) % 2;
            case (mode)
                1:       f = msb ? b1 : b0;
                2:       f = !(msb && !(b0 && l6));
                default: f = b0 && b1;
            endcase
            ones += int'(f);
            p = 0;
            for (int j = 0; j < 8; j++) p ^= ((l & 'h2D) >> j) & 1;
            l = p * 128 + l / 2;
        end
        return ones;
    endfunction

    // Starts a run from IDLE or DONE and returns at the done cycle (bounded).
    task automatic do_run(input int mode, input int x0, input int x1, input bit jitter,
                          output int res, output int n, output int sum, output int vn,
                          output int busy1);
        bus.mode_i  = 2'(mode);
        bus.x_i     = {8'(x1), 8'(x0)};
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        busy1 = int'(bus.busy_o);
        n = 1; sum = 0; vn = 0;
        while (bus.done_o !== 1'b1 && n < 400) begin
            if (jitter) begin
                bus.x_i    = 16'($urandom);
                bus.mode_i = 2'($urandom);
            end
            tick();
            n++;
            if (bus.stream_vld_o) begin
                vn++;
                sum += int'(bus.stream_o);
            end
        end
        res = int'(bus.result_o);
    endtask

    int hv_mode[8] = '{0, 0, 2, 2, 1, 1, 3, 0};
    int hv_x0[8]   = '{0, 255, 0, 255, 0, 255, 255, 255};
    int hv_x1[8]   = '{255, 255, 0, 0, 255, 0, 255, 0};
    int hv_exp[8]  = '{0, 254, 127, 190, 127, 127, 254, 0};

    initial begin
        int res, n, sum, vn, busy1, first_ret, distinct, saw_done, m, x0, x1;
        real err_sum, ideal;
        bit seen[256];

        bus.start_i = 1'b0;
        bus.mode_i  = 2'd0;
        bus.x_i     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_busy",   int'(bus.busy_o),       0);
        chk("rst_done",   int'(bus.done_o),       0);
        chk("rst_result", int'(bus.result_o),     0);
        chk("rst_stream", int'(bus.stream_o),     0);
        chk("rst_vld",    int'(bus.stream_vld_o), 0);

        // LFSR period on a standalone instance
        lf_load = 1'b1; tick(); lf_load = 1'b0;
        lf_en = 1'b1;
        first_ret = 0; distinct = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (!seen[lf_val]) distinct++;
            seen[lf_val] = 1'b1;
            if (lf_val == 8'h01 && first_ret == 0) first_ret = i;
        end
        lf_en = 1'b0;
        chk("lfsr_period",   first_ret,    255);
        chk("lfsr_distinct", distinct,     255);
        chk("lfsr_no_zero",  int'(seen[0]), 0);

        // mode 0 reference run + handshake timing
        do_run(0, 128, 255, 1'b0, res, n, sum, vn, busy1);
        chk("m0_result",   res, model(0, 128, 255));
        chk("hs_latency",  n, 256);
        chk("hs_busy1",    busy1, 1);
        chk("hs_busy_done", int'(bus.busy_o), 0);
        chk("stream_sum",  sum, res);
        chk("stream_vlds", vn, 255);
        tick();
        chk("hs_done_pulse", int'(bus.done_o), 0);
        chk("hs_idle_busy",  int'(bus.busy_o), 0);

        // hand-computed full-period vectors
        for (int i = 0; i < 8; i++) begin
            do_run(hv_mode[i], hv_x0[i], hv_x1[i], 1'b0, res, n, sum, vn, busy1);
            chk($sformatf("hand%0d_m%0d", i, hv_mode[i]), res, hv_exp[i]);
            tick();
        end

        // start held high through RUN must not restart
        bus.mode_i = 2'd1; bus.x_i = {8'd60, 8'd200};
        bus.start_i = 1'b1;
        tick();
        n = 1;
        while (bus.done_o !== 1'b1 && n < 400) begin
            if (n == 100) bus.start_i = 1'b0;
            tick();
            n++;
        end
        chk("held_start_latency", n, 256);
        chk("held_start_result", int'(bus.result_o), model(1, 200, 60));

        // start in the DONE cycle begins the next run immediately
        do_run(2, 77, 0, 1'b0, res, n, sum, vn, busy1);
        chk("done_restart_busy", busy1, 1);
        chk("done_restart_lat",  n, 256);
        chk("done_restart_res",  res, model(2, 77, 0));
        tick();

        // operands and mode changing every cycle during RUN
        do_run(0, 128, 255, 1'b1, res, n, sum, vn, busy1);
        chk("capture_m0", res, model(0, 128, 255));
        tick();
        do_run(2, 33, 9, 1'b1, res, n, sum, vn, busy1);
        chk("capture_m2", res, model(2, 33, 9));
        tick();

        // reset at cycle 100 of a run
        bus.mode_i = 2'd0; bus.x_i = {8'd255, 8'd128};
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (bus.done_o) saw_done++;
        end
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_no_done", saw_done, 0);
        chk("abort_busy",    int'(bus.busy_o),       0);
        chk("abort_done",    int'(bus.done_o),       0);
        chk("abort_result",  int'(bus.result_o),     0);
        chk("abort_vld",     int'(bus.stream_vld_o), 0);
        tick();
        do_run(0, 128, 255, 1'b0, res, n, sum, vn, busy1);
        chk("after_abort_res", res, model(0, 128, 255));
        chk("after_abort_lat", n, 256);
        tick();

        // random modes 1 and 2
        err_sum = 0.0;
        for (int i = 0; i < 200; i++) begin
            m  = 1 + (i % 2);
            x0 = int'($urandom_range(0, 255));
            x1 = int'($urandom_range(0, 255));
            do_run(m, x0, x1, 1'b0, res, n, sum, vn, busy1);
            chk($sformatf("rand%0d_m%0d_%0d_%0d", i, m, x0, x1), res, model(m, x0, x1));
            if (m == 1) ideal = 0.5 * real'(x0 + x1) / 256.0 * 255.0;
            else        ideal = (0.5 + 0.25 * real'(x0) / 256.0) * 255.0;
            err_sum += real'(res) - ideal;
            tick();
        end
        chk("mean_err_in_8", int'((err_sum / 200.0) <= 8.0 && (err_sum / 200.0) >= -8.0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
